c1_weight_fetch_ctrl: RTL and testbench

Requester side of the C1 weight-memory handshake (weight_req/kernel_idx -> 25 signed weights + weight_valid). On a start pulse, it walks kernels 0..NUM_KERNELS-1 in order. For each kernel it fetches the 25 weights, latches them into a local bank, and presents them to the C1 conv engine. It holds them until the engine reports the feature map done. Also produces a per-kernel weight sum for debug, and flags a timeout if the memory never responds.

---
 rtl/c1_weight_fetch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_c1_weight_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/c1_weight_fetch_ctrl.sv
// C1 weight fetch controller: sweeps kernels 0..NUM_KERNELS-1, fetches each
// kernel's 25 weights from weight memory, holds them in a local bank for the
// conv engine until it reports the feature map done, and raises a sticky
// timeout flag if memory never answers a request.
module c1_weight_fetch_ctrl #(
  parameter int NUM_KERNELS = 6,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               weight_req,
  output logic [2:0]         kernel_idx,
  input  logic               weight_valid,
  input  logic signed [7:0]  weight_0,  weight_1,  weight_2,  weight_3,  weight_4,
  input  logic signed [7:0]  weight_5,  weight_6,  weight_7,  weight_8,  weight_9,
  input  logic signed [7:0]  weight_10, weight_11, weight_12, weight_13, weight_14,
  input  logic signed [7:0]  weight_15, weight_16, weight_17, weight_18, weight_19,
  input  logic signed [7:0]  weight_20, weight_21, weight_22, weight_23, weight_24,
  output logic               kernel_valid,
  output logic [2:0]         kernel_id,
  output logic signed [7:0]  kw_0,  kw_1,  kw_2,  kw_3,  kw_4,
  output logic signed [7:0]  kw_5,  kw_6,  kw_7,  kw_8,  kw_9,
  output logic signed [7:0]  kw_10, kw_11, kw_12, kw_13, kw_14,
  output logic signed [7:0]  kw_15, kw_16, kw_17, kw_18, kw_19,
  output logic signed [7:0]  kw_20, kw_21, kw_22, kw_23, kw_24,
  output logic signed [12:0] kernel_sum,
  input  logic               conv_done,
  output logic               busy,
  output logic               all_done,
  output logic               timeout_err
);

  localparam int         TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0] KLAST      = 3'(NUM_KERNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RELEASE, S_PRESENT, S_DONE, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             kcnt_q, kcnt_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   weight_req_q, weight_req_d;
  logic [2:0]             kernel_idx_q, kernel_idx_d;
  logic                   kernel_valid_q, kernel_valid_d;
  logic [2:0]             kernel_id_q, kernel_id_d;
  logic signed [12:0]     kernel_sum_q, kernel_sum_d;
  logic                   busy_q, busy_d;
  logic                   all_done_q, all_done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic signed [7:0]      kw_q [25];
  logic signed [7:0]      kw_d [25];
  logic signed [7:0]      w_in [25];
  logic signed [12:0]     sum_in;

  // Flatten the individual weight ports into an array for uniform handling.
  assign w_in[0]  = weight_0;  assign w_in[1]  = weight_1;  assign w_in[2]  = weight_2;
  assign w_in[3]  = weight_3;  assign w_in[4]  = weight_4;  assign w_in[5]  = weight_5;
  assign w_in[6]  = weight_6;  assign w_in[7]  = weight_7;  assign w_in[8]  = weight_8;
  assign w_in[9]  = weight_9;  assign w_in[10] = weight_10; assign w_in[11] = weight_11;
  assign w_in[12] = weight_12; assign w_in[13] = weight_13; assign w_in[14] = weight_14;
  assign w_in[15] = weight_15; assign w_in[16] = weight_16; assign w_in[17] = weight_17;
  assign w_in[18] = weight_18; assign w_in[19] = weight_19; assign w_in[20] = weight_20;
  assign w_in[21] = weight_21; assign w_in[22] = weight_22; assign w_in[23] = weight_23;
  assign w_in[24] = weight_24;

  assign kw_0  = kw_q[0];  assign kw_1  = kw_q[1];  assign kw_2  = kw_q[2];
  assign kw_3  = kw_q[3];  assign kw_4  = kw_q[4];  assign kw_5  = kw_q[5];
  assign kw_6  = kw_q[6];  assign kw_7  = kw_q[7];  assign kw_8  = kw_q[8];
  assign kw_9  = kw_q[9];  assign kw_10 = kw_q[10]; assign kw_11 = kw_q[11];
  assign kw_12 = kw_q[12]; assign kw_13 = kw_q[13]; assign kw_14 = kw_q[14];
  assign kw_15 = kw_q[15]; assign kw_16 = kw_q[16]; assign kw_17 = kw_q[17];
  assign kw_18 = kw_q[18]; assign kw_19 = kw_q[19]; assign kw_20 = kw_q[20];
  assign kw_21 = kw_q[21]; assign kw_22 = kw_q[22]; assign kw_23 = kw_q[23];
  assign kw_24 = kw_q[24];

  assign weight_req   = weight_req_q;
  assign kernel_idx   = kernel_idx_q;
  assign kernel_valid = kernel_valid_q;
  assign kernel_id    = kernel_id_q;
  assign kernel_sum   = kernel_sum_q;
  assign busy         = busy_q;
  assign all_done     = all_done_q;
  assign timeout_err  = timeout_err_q;

  // Sum of the incoming weights; 13 bits holds 25 * [-128,127] without wrap.
  always_comb begin
    sum_in = '0;
    for (int i = 0; i < 25; i++) begin
      sum_in = sum_in + {{5{w_in[i][7]}}, w_in[i]};
    end
  end

  // Next-state logic; every output is the registered image of the next state.
  always_comb begin
    state_d       = state_q;
    kcnt_d        = kcnt_q;
    tcnt_d        = tcnt_q;
    kw_d          = kw_q;
    kernel_id_d   = kernel_id_q;
    kernel_sum_d  = kernel_sum_q;
    timeout_err_d = timeout_err_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            kcnt_d        = '0;
            tcnt_d        = '0;
            timeout_err_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        S_REQ: begin
          // Timeout outranks a response arriving on the final cycle.
          if (tcnt_q == TCNT_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_ERR;
          end else if (weight_valid) begin
            kw_d         = w_in;
            kernel_sum_d = sum_in;
            kernel_id_d  = kcnt_q;
            state_d      = S_RELEASE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        // Let the responder drop valid before anything new can be requested.
        S_RELEASE: begin
          if (!weight_valid) state_d = S_PRESENT;
        end
        S_PRESENT: begin
          if (conv_done) begin
            if (kcnt_q == KLAST) begin
              state_d = S_DONE;
            end else begin
              kcnt_d  = kcnt_q + 3'd1;
              tcnt_d  = '0;
              state_d = S_REQ;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    weight_req_d   = (state_d == S_REQ);
    kernel_valid_d = (state_d == S_PRESENT);
    busy_d         = (state_d != S_IDLE);
    all_done_d     = (state_d == S_DONE);
    kernel_idx_d   = kcnt_d;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      kcnt_q         <= '0;
      tcnt_q         <= '0;
      weight_req_q   <= 1'b0;
      kernel_idx_q   <= '0;
      kernel_valid_q <= 1'b0;
      kernel_id_q    <= '0;
      kernel_sum_q   <= '0;
      busy_q         <= 1'b0;
      all_done_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
      for (int i = 0; i < 25; i++) kw_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      kcnt_q         <= kcnt_d;
      tcnt_q         <= tcnt_d;
      weight_req_q   <= weight_req_d;
      kernel_idx_q   <= kernel_idx_d;
      kernel_valid_q <= kernel_valid_d;
      kernel_id_q    <= kernel_id_d;
      kernel_sum_q   <= kernel_sum_d;
      busy_q         <= busy_d;
      all_done_q     <= all_done_d;
      timeout_err_q  <= timeout_err_d;
      kw_q           <= kw_d;
    end
  end

endmodule

// File: tb/tb_c1_weight_fetch_ctrl.sv
// Directed bench for c1_weight_fetch_ctrl with a 2-cycle weight responder.
module tb_c1_weight_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic conv_done = 1'b0;
  logic weight_valid;
  logic weight_req, kernel_valid, busy, all_done, timeout_err;
  logic [2:0] kernel_idx, kernel_id;
  logic signed [12:0] kernel_sum;
  logic signed [7:0] wt [25];
  logic signed [7:0] kw [25];

  int checks = 0;
  int failures = 0;
  int mode = 0;       // 0: formula 25k+i-75, 1: all -128, 2: all 127
  int silent_k = -1;  // responder never answers this kernel
  int rcnt = 0;
  int viol = 0;
  int done_cnt = 0;
  logic prev_req = 1'b0;
  logic [2:0] prev_idx = 3'd0;
  int lat;
  int cyc;

  always #5 clk = ~clk;

  c1_weight_fetch_ctrl #(.NUM_KERNELS(6), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .weight_req(weight_req), .kernel_idx(kernel_idx), .weight_valid(weight_valid),
    .weight_0(wt[0]), .weight_1(wt[1]), .weight_2(wt[2]), .weight_3(wt[3]), .weight_4(wt[4]),
    .weight_5(wt[5]), .weight_6(wt[6]), .weight_7(wt[7]), .weight_8(wt[8]), .weight_9(wt[9]),
    .weight_10(wt[10]), .weight_11(wt[11]), .weight_12(wt[12]), .weight_13(wt[13]), .weight_14(wt[14]),
    .weight_15(wt[15]), .weight_16(wt[16]), .weight_17(wt[17]), .weight_18(wt[18]), .weight_19(wt[19]),
    .weight_20(wt[20]), .weight_21(wt[21]), .weight_22(wt[22]), .weight_23(wt[23]), .weight_24(wt[24]),
    .kernel_valid(kernel_valid), .kernel_id(kernel_id),
    .kw_0(kw[0]), .kw_1(kw[1]), .kw_2(kw[2]), .kw_3(kw[3]), .kw_4(kw[4]),
    .kw_5(kw[5]), .kw_6(kw[6]), .kw_7(kw[7]), .kw_8(kw[8]), .kw_9(kw[9]),
    .kw_10(kw[10]), .kw_11(kw[11]), .kw_12(kw[12]), .kw_13(kw[13]), .kw_14(kw[14]),
    .kw_15(kw[15]), .kw_16(kw[16]), .kw_17(kw[17]), .kw_18(kw[18]), .kw_19(kw[19]),
    .kw_20(kw[20]), .kw_21(kw[21]), .kw_22(kw[22]), .kw_23(kw[23]), .kw_24(kw[24]),
    .kernel_sum(kernel_sum), .conv_done(conv_done),
    .busy(busy), .all_done(all_done), .timeout_err(timeout_err)
  );

  // Weight memory contents as a function of the requested kernel.
  always_comb begin
    for (int i = 0; i < 25; i++) begin
      if (mode == 1)      wt[i] = -8'sd128;
      else if (mode == 2) wt[i] = 8'sd127;
      else                wt[i] = 8'(25 * int'(kernel_idx) + i - 75);
    end
  end

  // Responder: valid two edges after the request is seen, held until it drops.
  always @(posedge clk) begin
    if (!rst_n || !weight_req) begin
      weight_valid <= 1'b0;
      rcnt <= 0;
    end else if (int'(kernel_idx) == silent_k) begin
      weight_valid <= 1'b0;
    end else if (rcnt >= 1) begin
      weight_valid <= 1'b1;
    end else begin
      rcnt <= rcnt + 1;
    end
  end

  // Handshake ordering monitor and all_done pulse counter.
  always @(negedge clk) begin
    if (weight_req && !prev_req && weight_valid) viol++;
    if (weight_req && prev_req && kernel_idx != prev_idx) viol++;
    if (all_done) done_cnt++;
    prev_req = weight_req;
    prev_idx = kernel_idx;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_kv(input string tag, output int n);
    n = 0;
    while (!kernel_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!kernel_valid) check(tag, 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic consume(input int k);
    conv_done = 1'b1;
    @(negedge clk) conv_done = 1'b0;
    check($sformatf("kv_drop_k%0d", k), kernel_valid, 0);
  endtask

  // Wait for kernel k under the formula weights, check the bank, release it.
  task automatic serve(input int k);
    int n;
    wait_kv($sformatf("kv_wait_k%0d", k), n);
    check($sformatf("kid_k%0d", k), kernel_id, k);
    check($sformatf("kw0_k%0d", k), kw[0], 25 * k - 75);
    check($sformatf("kw24_k%0d", k), kw[24], 25 * k - 51);
    check($sformatf("sum_k%0d", k), kernel_sum, 625 * k - 1575);
    $display("kernel %0d: kw0=%0d kw24=%0d sum=%0d", k, kw[0], kw[24], kernel_sum);
    consume(k);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", weight_req, 0);
    check("rst_idx", kernel_idx, 0);
    check("rst_kv", kernel_valid, 0);
    check("rst_kid", kernel_id, 0);
    check("rst_kw0", kw[0], 0);
    check("rst_sum", kernel_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_done", all_done, 0);
    check("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep with latency measurement on kernel 0
    pulse_start();
    check("req_rise", weight_req, 1);
    check("req_idx0", kernel_idx, 0);
    check("busy_run", busy, 1);
    wait_kv("kv_wait_first", lat);
    check("latency", lat, 5);
    for (int k = 0; k < 6; k++) serve(k);
    check("all_done_pulse", all_done, 1);
    @(negedge clk);
    check("all_done_drop", all_done, 0);
    check("busy_idle", busy, 0);
    @(negedge clk);
    check("all_done_once", done_cnt, 1);

    // Timeout on kernel 2
    silent_k = 2;
    pulse_start();
    serve(0);
    serve(1);
    cyc = 0;
    while (weight_req && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("req_hold_cycles", cyc, 64);
    check("terr_set", timeout_err, 1);
    @(negedge clk);
    check("terr_busy", busy, 0);
    check("terr_sticky", timeout_err, 1);
    check("terr_no_done", done_cnt, 1);
    $display("timeout: req held %0d cycles", cyc);
    silent_k = -1;
    pulse_start();
    check("terr_clear", timeout_err, 0);
    check("restart_idx", kernel_idx, 0);

    // Abort during REQ of kernel 3
    serve(0);
    serve(1);
    serve(2);
    check("abort_pre_idx", kernel_idx, 3);
    check("abort_pre_req", weight_req, 1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_req", weight_req, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    mode = 1;
    pulse_start();
    check("abort_restart_idx", kernel_idx, 0);
    check("abort_restart_req", weight_req, 1);

    // Extreme weights: all -128 then all 127
    wait_kv("kv_wait_neg", lat);
    check("sum_min", kernel_sum, -3200);
    check("kw24_min", kw[24], -128);
    $display("extreme min: sum=%0d", kernel_sum);
    mode = 2;
    consume(0);
    wait_kv("kv_wait_pos", lat);
    check("sum_max", kernel_sum, 3175);
    check("kw0_max", kw[0], 127);
    check("kid_max", kernel_id, 1);
    $display("extreme max: sum=%0d", kernel_sum);

    // Asynchronous reset in PRESENT, between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("areset_kv", kernel_valid, 0);
    check("areset_busy", busy, 0);
    check("areset_kw0", kw[0], 0);
    check("areset_sum", kernel_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("areset_no_done", done_cnt, 1);
    check("handshake_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench time limit");
  end

endmodule
